// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result streamer: FSM encodings, order
// select constants and a width helper that never returns zero.
package matrix_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic ORDER_ROW = 1'b0;
   localparam logic ORDER_COL = 1'b1;

   // Index/address widths must stay at least one bit even for 1-entry ranges.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// RAM read port plus byte stream port of the streamer, bundled together.
// master = streamer side, slave = RAM/sink side.
interface matrix_result_streamer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output rd_en, rd_addr, out_data, out_valid,
      input  rd_data, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_data, out_valid,
      output rd_data, out_ready
   );
endinterface

// File: rtl/matrix_result_streamer_serializer.sv
// Holds one element and shifts it out MSB byte first while i_active;
// o_last flags the transfer of the element's final byte.
module word_byte_serializer
   import matrix_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_active,
   input  logic              i_flush,
   input  logic              i_ready,
   output logic [7:0]        o_data,
   output logic              o_valid,
   output logic              o_last
);
   localparam int BYTES = DATA_W / 8;
   localparam int BC_W  = clog2_min1(BYTES);

   logic [DATA_W-1:0] r_shreg;
   logic [BC_W-1:0]   r_byte_cnt;
   logic              w_xfer;

   assign w_xfer = i_active & i_ready;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_shreg    <= '0;
         r_byte_cnt <= '0;
      end else if (i_load) begin
         r_shreg    <= i_data;
         r_byte_cnt <= '0;
      end else if (w_xfer) begin
         r_shreg    <= r_shreg << 8;
         r_byte_cnt <= r_byte_cnt + 1'b1;
      end
   end

   assign o_data  = r_shreg[DATA_W-1 -: 8];
   assign o_valid = i_active;
   assign o_last  = w_xfer && (r_byte_cnt == BC_W'(BYTES - 1));

endmodule

// File: rtl/matrix_result_streamer.sv
// Walks a ROWS x COLS result RAM in row- or column-major order and streams
// every element as big-endian bytes on a valid/ready port.
module matrix_result_streamer
   import matrix_pkg::*;
#(
   parameter  int ROWS   = 8,
   parameter  int COLS   = 8,
   parameter  int DATA_W = 32,
   localparam int ADDR_W = clog2_min1(ROWS * COLS),
   localparam int RI_W   = clog2_min1(ROWS),
   localparam int CI_W   = clog2_min1(COLS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      col_major,
   input  logic                      abort,
   matrix_result_streamer_if.master  bus,
   output logic [RI_W-1:0]           i,
   output logic [CI_W-1:0]           j,
   output logic                      busy,
   output logic                      done
);
   state_t            r_state;
   state_t            w_state_next;
   logic              r_col_major;
   logic [RI_W-1:0]   r_i;
   logic [CI_W-1:0]   r_j;
   logic [RI_W-1:0]   w_i_next;
   logic [CI_W-1:0]   w_j_next;
   logic              w_i_wrap;
   logic              w_j_wrap;
   logic              w_last_elem;
   logic              w_last_byte;
   logic              w_accept;
   logic              w_abort;
   logic              w_busy;
   logic              w_done;
   logic              w_rd_en;
   logic              w_load;
   logic              w_send;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [7:0]        w_out_data;
   logic              w_out_valid;

   assign w_i_wrap    = (r_i == RI_W'(ROWS - 1));
   assign w_j_wrap    = (r_j == CI_W'(COLS - 1));
   assign w_last_elem = w_i_wrap && w_j_wrap;
   assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_abort     = abort && w_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Abort overrides every busy transition; start is only seen when idle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: if (start) w_state_next = READ;
         READ:       w_state_next = WAIT;
         WAIT:       w_state_next = SEND;
         SEND:       if (w_last_byte) w_state_next = w_last_elem ? DONE : READ;
         default:    w_state_next = IDLE;
      endcase
      if (w_abort) begin
         w_state_next = IDLE;
      end
   end

   always_comb begin
      w_rd_en = 1'b0;
      w_load  = 1'b0;
      w_send  = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         READ:    begin w_rd_en = 1'b1; w_busy = 1'b1; end
         WAIT:    begin w_load  = 1'b1; w_busy = 1'b1; end
         SEND:    begin w_send  = 1'b1; w_busy = 1'b1; end
         DONE:    w_done = 1'b1;
         default: ;
      endcase
   end

   // The inner index wraps first; the outer one steps only on that wrap.
   always_comb begin
      w_i_next = r_i;
      w_j_next = r_j;
      if (r_col_major == ORDER_COL) begin
         w_i_next = w_i_wrap ? '0 : r_i + 1'b1;
         if (w_i_wrap) w_j_next = w_j_wrap ? '0 : r_j + 1'b1;
      end else begin
         w_j_next = w_j_wrap ? '0 : r_j + 1'b1;
         if (w_j_wrap) w_i_next = w_i_wrap ? '0 : r_i + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_i         <= '0;
         r_j         <= '0;
         r_col_major <= ORDER_ROW;
      end else if (w_accept) begin
         r_i         <= '0;
         r_j         <= '0;
         r_col_major <= col_major;
      end else if (w_abort) begin
         r_i <= '0;
         r_j <= '0;
      end else if (w_last_byte) begin
         r_i <= w_i_next;
         r_j <= w_j_next;
      end
   end

   // Storage is always row-major regardless of the walk order.
   assign w_rd_addr = w_rd_en ? (ADDR_W'(r_i) * ADDR_W'(COLS) + ADDR_W'(r_j)) : '0;

   word_byte_serializer #(
      .DATA_W (DATA_W)
   ) u_serializer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_data   (bus.rd_data),
      .i_active (w_send),
      .i_flush  (w_abort),
      .i_ready  (bus.out_ready),
      .o_data   (w_out_data),
      .o_valid  (w_out_valid),
      .o_last   (w_last_byte)
   );

   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = w_rd_addr;
   assign bus.out_data  = w_out_data;
   assign bus.out_valid = w_out_valid;
   assign i             = r_i;
   assign j             = r_j;
   assign busy          = w_busy;
   assign done          = w_done;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench: a 2x2x32-bit streamer for ordering, stalls, abort and reset,
// plus a 1x1x8-bit streamer for the degenerate single-element case.
module tb_matrix_result_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, cm_a, abort_a;
   logic       start_b, cm_b, abort_b;
   logic [0:0] i_a, j_a, i_b, j_b;
   logic       busy_a, done_a, busy_b, done_b;

   matrix_result_streamer_if #(.DATA_W(32), .ADDR_W(2)) bus_a ();
   matrix_result_streamer_if #(.DATA_W(8),  .ADDR_W(1)) bus_b ();

   matrix_result_streamer #(.ROWS(2), .COLS(2), .DATA_W(32)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .col_major(cm_a), .abort(abort_a),
      .bus(bus_a), .i(i_a), .j(j_a), .busy(busy_a), .done(done_a)
   );

   matrix_result_streamer #(.ROWS(1), .COLS(1), .DATA_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .col_major(cm_b), .abort(abort_b),
      .bus(bus_b), .i(i_b), .j(j_b), .busy(busy_b), .done(done_b)
   );

   // Result RAMs with one cycle read latency.
   logic [31:0] ram_a [4];
   logic [7:0]  ram_b_word;

   always @(posedge clk) begin
      if (bus_a.rd_en) bus_a.rd_data <= ram_a[bus_a.rd_addr];
      if (bus_b.rd_en) bus_b.rd_data <= ram_b_word;
   end

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] got_bytes[$];
   logic [7:0] exp_bytes[$];
   int         got_i[$], got_j[$], exp_i[$], exp_j[$];
   int         cycles_a;

   // Reference order: the inner loop walks j for row-major, i for column-major.
   task automatic build_expect(input bit cm);
      logic [31:0] word;
      int ii, jj;
      exp_bytes.delete(); exp_i.delete(); exp_j.delete();
      for (int outer = 0; outer < 2; outer++) begin
         for (int inner = 0; inner < 2; inner++) begin
            ii = cm ? inner : outer;
            jj = cm ? outer : inner;
            word = 32'h0A0B0C00 + 32'(ii * 2 + jj);
            exp_i.push_back(ii);
            exp_j.push_back(jj);
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(word[b*8 +: 8]);
         end
      end
   endtask

   // Runs one dump on DUT a; stop_at >= 0 applies abort (or rst) for one cycle
   // once that many bytes were accepted and the next one is being offered.
   task automatic run_a(input bit cm, input bit toggle, input bit poke,
                        input int stop_at, input bit stop_rst);
      logic       held_valid;
      logic [7:0] held_data;
      got_bytes.delete(); got_i.delete(); got_j.delete();
      held_valid = 1'b0;
      held_data  = 8'h00;
      cm_a    = cm;
      start_a = 1'b1;
      @(negedge clk);
      start_a  = 1'b0;
      cycles_a = 0;
      if (poke) cm_a = ~cm;
      while (!done_a && cycles_a < 400) begin
         bus_a.out_ready = toggle ? ((cycles_a % 4 == 0) || (cycles_a % 4 == 3)) : 1'b1;
         start_a = poke && busy_a && (cycles_a % 7 == 3);
         if (held_valid) begin
            check_value("stall_valid", 32'(bus_a.out_valid), 32'd1);
            check_value("stall_data", 32'(bus_a.out_data), 32'(held_data));
         end
         held_valid = bus_a.out_valid && !bus_a.out_ready;
         held_data  = bus_a.out_data;
         if (stop_at >= 0 && got_bytes.size() == stop_at && bus_a.out_valid) begin
            if (stop_rst) rst = 1'b1;
            else abort_a = 1'b1;
            @(negedge clk);
            rst = 1'b0; abort_a = 1'b0; start_a = 1'b0;
            $display("dump stopped after %0d bytes (%s)", got_bytes.size(), stop_rst ? "rst" : "abort");
            return;
         end
         if (bus_a.out_valid && bus_a.out_ready) begin
            if (got_bytes.size() % 4 == 0) begin
               got_i.push_back(int'(i_a));
               got_j.push_back(int'(j_a));
            end
            got_bytes.push_back(bus_a.out_data);
         end
         @(negedge clk);
         cycles_a++;
      end
      start_a = 1'b0;
      cm_a    = cm;
      bus_a.out_ready = 1'b1;
      check_value("done_timeout", 32'(done_a), 32'd1);
      $display("dump cm=%0d toggle=%0d: %0d bytes, done after %0d cycles",
               cm, toggle, got_bytes.size(), cycles_a);
   endtask

   task automatic compare_stream(input string tag);
      check_value({tag, "_count"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
      for (int b = 0; b < got_bytes.size() && b < exp_bytes.size(); b++)
         check_value({tag, "_byte"}, 32'(got_bytes[b]), 32'(exp_bytes[b]));
      for (int e = 0; e < got_i.size() && e < exp_i.size(); e++) begin
         check_value({tag, "_i"}, 32'(got_i[e]), 32'(exp_i[e]));
         check_value({tag, "_j"}, 32'(got_j[e]), 32'(exp_j[e]));
      end
   endtask

   task automatic check_idle_a(input string tag);
      check_value({tag, "_valid"}, 32'(bus_a.out_valid), 32'd0);
      check_value({tag, "_rd_en"}, 32'(bus_a.rd_en), 32'd0);
      check_value({tag, "_busy"}, 32'(busy_a), 32'd0);
      check_value({tag, "_done"}, 32'(done_a), 32'd0);
      check_value({tag, "_i"}, 32'(i_a), 32'd0);
      check_value({tag, "_j"}, 32'(j_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, nb, last_xfer;
      rst = 1'b1;
      start_a = 1'b0; cm_a = 1'b0; abort_a = 1'b0;
      start_b = 1'b0; cm_b = 1'b0; abort_b = 1'b0;
      bus_a.out_ready = 1'b1;
      bus_b.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) ram_a[k] = 32'h0A0B0C00 + 32'(k);
      ram_b_word = 8'h5A;
      repeat (3) @(negedge clk);

      check_idle_a("reset");
      check_value("reset_out_data", 32'(bus_a.out_data), 32'd0);
      check_value("reset_rd_addr", 32'(bus_a.rd_addr), 32'd0);
      check_value("reset_b_done", 32'(done_b), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Row-major with an always-ready sink.
      build_expect(1'b0);
      run_a(1'b0, 1'b0, 1'b0, -1, 1'b0);
      compare_stream("rowmaj");
      check_value("rowmaj_latency", 32'(cycles_a), 32'd24);
      check_value("rowmaj_busy_end", 32'(busy_a), 32'd0);

      // Column-major.
      build_expect(1'b1);
      run_a(1'b1, 1'b0, 1'b0, -1, 1'b0);
      compare_stream("colmaj");
      check_value("colmaj_latency", 32'(cycles_a), 32'd24);

      // Back-pressure with ready pattern 1,0,0,1.
      build_expect(1'b0);
      run_a(1'b0, 1'b1, 1'b0, -1, 1'b0);
      compare_stream("stall");

      // Abort on the 3rd byte of element (0,1), then replay.
      run_a(1'b0, 1'b0, 1'b0, 6, 1'b0);
      check_idle_a("abort");
      check_value("abort_bytes", 32'(got_bytes.size()), 32'd6);
      build_expect(1'b0);
      run_a(1'b0, 1'b0, 1'b0, -1, 1'b0);
      compare_stream("replay");
      check_value("replay_latency", 32'(cycles_a), 32'd24);

      // Reset mid-SEND, then a full dump with start/col_major poked while busy.
      run_a(1'b0, 1'b0, 1'b0, 5, 1'b1);
      check_idle_a("midrst");
      check_value("midrst_out_data", 32'(bus_a.out_data), 32'd0);
      check_value("midrst_rd_addr", 32'(bus_a.rd_addr), 32'd0);
      run_a(1'b0, 1'b0, 1'b1, -1, 1'b0);
      compare_stream("poked");
      check_value("poked_latency", 32'(cycles_a), 32'd24);

      // Single 8-bit element, run twice (second start from DONE).
      for (int rep = 0; rep < 2; rep++) begin
         start_b = 1'b1;
         @(negedge clk);
         start_b = 1'b0;
         c = 0; nb = 0; last_xfer = -1;
         check_value("single_done_drop", 32'(done_b), 32'd0);
         check_value("single_busy", 32'(busy_b), 32'd1);
         while (!done_b && c < 50) begin
            if (bus_b.rd_en) check_value("single_rd_addr", 32'(bus_b.rd_addr), 32'd0);
            if (bus_b.out_valid && bus_b.out_ready) begin
               check_value("single_byte", 32'(bus_b.out_data), 32'h5A);
               check_value("single_i", 32'(i_b), 32'd0);
               check_value("single_j", 32'(j_b), 32'd0);
               nb++;
               last_xfer = c;
            end
            @(negedge clk);
            c++;
         end
         check_value("single_done", 32'(done_b), 32'd1);
         check_value("single_count", 32'(nb), 32'd1);
         check_value("single_latency", 32'(c), 32'd3);
         check_value("single_done_next", 32'(c - last_xfer), 32'd1);
         $display("single run %0d: %0d byte(s), done after %0d cycles", rep, nb, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
